regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Writeback stage directly upstream of the 32x32 register file write port (we/waddr/wdata).
- Merges two result sources onto the single write port: ALU results (valid/ready handshake, buffered in a small FIFO) and load returns (no backpressure, highest priority).
- Keeps a pending-load scoreboard so the issue stage can stall on registers still awaiting a load.
- Registered outputs drive the register file write port directly.

Parameters:
XLEN, 32, data width.
ALU_FIFO_DEPTH, 2, ALU result buffer entries. Power of two, >= 2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
alu_valid  in  1  ALU result present.
alu_ready  out  1  arbiter can accept an ALU result.
alu_rd  in  5  ALU destination register.
alu_data  in  XLEN  ALU result.
ld_valid  in  1  load return present. Always accepted.
ld_rd  in  5  load destination register.
ld_data  in  XLEN  load data.
busy_set_valid  in  1  issue stage dispatched a load.
busy_set_rd  in  5  destination of the dispatched load.
busy  out  32  pending-load scoreboard. Bit i set means xi is awaiting a load.
rf_we  out  1  to register file we.
rf_waddr  out  5  to register file waddr.
rf_wdata  out  XLEN  to register file wdata.
fifo_count  out  $clog2(ALU_FIFO_DEPTH)+1  ALU FIFO occupancy.

Behaviour:
- Reset, async on rst_n low: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO empty, fifo_count=0.
- alu_ready = (fifo_count < ALU_FIFO_DEPTH), combinational from registered count. It does not depend on a same-cycle pop. After reset, alu_ready=1.
- ALU accept: alu_valid && alu_ready at a rising edge.
  - alu_rd != 0: entry pushed.
  - alu_rd == 0: handshake completes, entry discarded, never written.
- Arbitration at each rising edge, into the output registers:
  1. If ld_valid && ld_rd != 0: load result loaded. rf_we=1 next cycle.
  2. Else if FIFO non-empty: head popped and loaded. rf_we=1.
  3. Else: rf_we=0. rf_waddr/rf_wdata hold their last values.
- ld_valid with ld_rd == 0: dropped. The FIFO head may pop in that same cycle.
- Load latency: 1 cycle (ld_valid sampled at edge E -> rf_we high in cycle after E).
- ALU latency without bypass: accepted at E0, earliest rf_we in cycle after E1.
- A load stalls FIFO draining for as long as ld_valid stays high. ALU writes are never lost; backpressure goes through alu_ready only.
- Push and pop in the same edge: count unchanged. Full FIFO + pop: alu_ready still 0 that cycle.
- FIFO pointers wrap modulo ALU_FIFO_DEPTH. Strict FIFO order.
- Scoreboard, evaluated at each edge:
  - Set: busy[busy_set_rd] set when busy_set_valid && busy_set_rd != 0.
  - Clear: busy[ld_rd] cleared when a load wins arbitration.
  - Same rd set and cleared in the same edge: set wins.
  - busy[0] is always 0.
  - Load to a non-busy register: written normally, no error.
- No write-address collision checking between the ALU and load paths. Program order is the issue stage's responsibility.
- Reset mid-operation: FIFO contents and pending busy bits are discarded. Outputs go to their reset values immediately.

Optional Feature:
WB_BYPASS_EN.
- Defined: when the FIFO is empty and no valid load with nonzero rd is present, an accepted ALU result (rd != 0) goes straight to the output registers on the same edge. It is not pushed. ALU latency becomes 1 cycle. In every other case the entry is pushed as normal.
- Undefined: every accepted ALU result passes through the FIFO. Minimum ALU latency is 2 cycles.

Test Plan:
- Reset: rst_n low mid-traffic with 2 entries queued -> rf_we=0, busy=0, fifo_count=0, alu_ready=1 immediately. No queued entry is ever written.
- Single ALU (rd=5, data=50), no loads -> exactly one rf_we pulse with waddr=5, wdata=50. Pulse appears in the cycle after E1 (no bypass) or after E0 (WB_BYPASS_EN).
- Collision: load (rd=3, 0xDEADBEEF) and ALU (rd=7, 70) presented on the same edge -> rd=3 written first, rd=7 in the following cycle. Register file reads back x3=0xDEADBEEF, x7=70.
- Backpressure: ld_valid held 4 cycles (rd=1..4) while 3 ALU results are offered -> alu_ready=0 after 2 accepts. All 4 loads written, then ALU results in push order, none lost.
- Scoreboard: busy_set rd=9 -> busy[9]=1. Load rd=9 wins arbitration -> busy[9]=0. Simultaneous set+clear on rd=9 -> busy[9] stays 1.
- x0 handling: ALU rd=0 and load rd=0 -> no rf_we. busy_set rd=0 -> busy[0]=0. Register file x0 reads 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Purpose : bundles the writeback-stage bus (ALU result, load return, scoreboard, register file write port).
// Latency : none; wires only.
// Backpressure: alu_valid/alu_ready is the only stalling handshake; loads and busy-set cannot be refused.
//
// Modports:
//   slave  - the writeback arbiter (consumes results, drives the register file port and scoreboard)
//   master - the surrounding pipeline / bench (produces results, observes write port and scoreboard)
interface regfile_wb_arbiter_if #(
  parameter int XLEN           = 32,
  parameter int ALU_FIFO_DEPTH = 2
);
  localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1;

  // ALU result channel (valid/ready)
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  // Load return channel (always accepted)
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  // Scoreboard set from the issue stage, and the scoreboard itself
  logic            busy_set_valid;
  logic [4:0]      busy_set_rd;
  logic [31:0]     busy;

  // Register file write port
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  // ALU buffer occupancy
  logic [CW-1:0]   fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  busy_set_valid, busy_set_rd,
    output alu_ready, busy, rf_we, rf_waddr, rf_wdata, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output busy_set_valid, busy_set_rd,
    input  alu_ready, busy, rf_we, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose : writeback arbiter in front of the 32x32 register file write port. Loads have absolute
//           priority; ALU results are buffered in a small FIFO and drained whenever no load is writing.
//           A 32-bit pending-load scoreboard is kept alongside for the issue stage.
// Ports   : clk, rst_n (async, active low) plus regfile_wb_arbiter_if.slave carrying
//           alu_valid/alu_ready/alu_rd/alu_data, ld_valid/ld_rd/ld_data, busy_set_valid/busy_set_rd,
//           busy, rf_we/rf_waddr/rf_wdata, fifo_count.
// Option  : define WB_BYPASS_EN to let an ALU result skip the empty FIFO and reach the write port
//           on the edge it is accepted. Undefined (default), every ALU result passes through the FIFO.

// Purpose : generic synchronous FIFO, registered head, power-of-two depth.
// Latency : an entry pushed at edge E is visible at head_dat after E.
// Backpressure: none internally; caller must not push when full nor pop when empty.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Pointers are exactly PW bits wide, so DEPTH being a power of two makes
  // the natural overflow the modulo-DEPTH wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_rdy) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_vld, pop_rdy})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// Purpose : merges load returns and buffered ALU results onto the register file write port; tracks pending loads.
// Latency : load 1 cycle; ALU 2 cycles through the FIFO (1 cycle when bypassing an empty FIFO with WB_BYPASS_EN).
// Backpressure: alu_ready deasserts while the FIFO holds ALU_FIFO_DEPTH entries; loads are never refused.
module regfile_wb_arbiter #(
  parameter int XLEN           = 32,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb
);
  localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ALU_FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t       alu_ent;
  wb_entry_t       head_ent;
  logic [CW-1:0]   count;

  logic            alu_acc;     // ALU handshake completes this edge
  logic            alu_keep;    // accepted and worth writing (rd != x0)
  logic            ld_win;      // load owns the write port this edge
  logic            fifo_nempty;
  logic            bypass;
  logic            push_vld;
  logic            pop_rdy;

  logic            rf_we_q,    rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_q,     busy_d;

  // Ready comes only from the registered count: a pop on the same edge does
  // not open a slot early, which keeps alu_ready off any combinational path
  // from ld_valid.
  assign wb.alu_ready = (count < DEPTH_C);

  assign alu_ent.rd   = wb.alu_rd;
  assign alu_ent.data = wb.alu_data;

  assign alu_acc     = wb.alu_valid && wb.alu_ready;
  assign alu_keep    = alu_acc && (wb.alu_rd != 5'd0);
  assign ld_win      = wb.ld_valid && (wb.ld_rd != 5'd0);
  assign fifo_nempty = (count != '0);

`ifdef WB_BYPASS_EN
  // Only when nothing older is queued and no load wants the port can an ALU
  // result go straight to the output registers without reordering anything.
  assign bypass = alu_keep && !fifo_nempty && !ld_win;
`else
  assign bypass = 1'b0;
`endif

  assign push_vld = alu_keep && !bypass;
  // A load with rd == x0 is dropped, so it does not block the FIFO head.
  assign pop_rdy  = fifo_nempty && !ld_win;

  fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (alu_ent),
    .pop_rdy  (pop_rdy),
    .head_dat (head_ent),
    .count    (count)
  );

  // Write-port selection: load, else FIFO head, else bypassed ALU result.
  // Address/data hold when idle so the register file sees a quiet bus.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (ld_win) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb.ld_rd;
      rf_wdata_d = wb.ld_data;
    end else if (pop_rdy) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_ent.rd;
      rf_wdata_d = head_ent.data;
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = alu_ent.rd;
      rf_wdata_d = alu_ent.data;
    end
  end

  // Scoreboard: the set is applied after the clear so a new load dispatched
  // to the same register on the edge the old one returns stays pending.
  always_comb begin
    busy_d = busy_q;
    if (ld_win) begin
      busy_d[wb.ld_rd] = 1'b0;
    end
    if (wb.busy_set_valid && (wb.busy_set_rd != 5'd0)) begin
      busy_d[wb.busy_set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign wb.rf_we      = rf_we_q;
  assign wb.rf_waddr   = rf_waddr_q;
  assign wb.rf_wdata   = rf_wdata_q;
  assign wb.busy       = busy_q;
  assign wb.fifo_count = count;
endmodule
